// File: rtl/execute_stage_md_pkg.sv
// Shared types for the execute stage with the RV "M" extension: ALU ops,
// multiply/divide ops, branch condition codes, decoded control and FSM states.
package execute_stage_md_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_t;

  // Bit 2 set means a divide/remainder operation.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src;
    logic       is_branch;
    logic       is_jump;
    logic       is_jalr;
    logic [2:0] br_funct3;
    logic       is_md;
    md_op_t     md_op;
  } control_type;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_t;

endpackage

// File: rtl/execute_stage_md_alu.sv
// Single-cycle integer ALU used by the execute stage.
module alu
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << sh;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $signed(a) >>> sh;
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage_md_muldiv.sv
// Multi-cycle multiply/divide unit: fixed-latency multiply and a restoring
// divider producing one quotient bit per cycle.
module muldiv_unit
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  // Handshake: start is honoured only in IDLE; busy is high from the start
  // cycle until the result is ready; done is high for the single cycle in
  // which result is valid. flush outside IDLE drops busy/done at once.
  localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  md_op_t           op_q;
  logic [XLEN-1:0]  a_q, b_q, quo, rem, dvsr, result_q;
  logic             q_neg, r_neg;

  logic            sgn_div;
  logic [XLEN-1:0] a_mag, b_mag;
  assign sgn_div = (op == MD_DIV) || (op == MD_REM);
  assign a_mag   = (sgn_div && a[XLEN-1]) ? -a : a;
  assign b_mag   = (sgn_div && b[XLEN-1]) ? -b : b;

  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] step_quo, step_rem, q_fix, r_fix, div_res;
  logic            div_zero;
  assign shifted  = {rem, quo[XLEN-1]};
  assign trial    = shifted - {1'b0, dvsr};
  assign step_quo = {quo[XLEN-2:0], ~trial[XLEN]};
  assign step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  // Signed overflow (MIN / -1) falls out of the magnitude math; only /0 is special.
  assign div_zero = (b_q == '0);
  assign q_fix    = div_zero ? '1 : (q_neg ? -step_quo : step_quo);
  assign r_fix    = div_zero ? a_q : (r_neg ? -step_rem : step_rem);
  assign div_res  = ((op_q == MD_REM) || (op_q == MD_REMU)) ? r_fix : q_fix;

  // Unsigned product, with the upper half corrected for signed operands.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   prod_hi, corr_a, corr_b, mul_res;
  assign prod    = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
  assign prod_hi = prod[2*XLEN-1:XLEN];
  assign corr_a  = a_q[XLEN-1] ? b_q : '0;
  assign corr_b  = b_q[XLEN-1] ? a_q : '0;

  always_comb begin
    mul_res = prod[XLEN-1:0];
    case (op_q)
      MD_MULH:   mul_res = prod_hi - corr_a - corr_b;
      MD_MULHSU: mul_res = prod_hi - corr_a;
      MD_MULHU:  mul_res = prod_hi;
      default:   mul_res = prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (flush && (state != ST_IDLE)) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          quo   <= a_mag;
          rem   <= '0;
          dvsr  <= b_mag;
          q_neg <= sgn_div && (a[XLEN-1] ^ b[XLEN-1]);
          r_neg <= sgn_div && a[XLEN-1];
          cnt   <= '0;
          state <= op[2] ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          if (cnt == CNT_W'(MUL_LATENCY - 1)) begin
            result_q <= mul_res;
            cnt      <= '0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DIV: begin
          quo <= step_quo;
          rem <= step_rem;
          if (cnt == CNT_W'(XLEN - 1)) begin
            result_q <= div_res;
            cnt      <= '0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = ((state == ST_IDLE) && start) ||
                     (((state == ST_MUL) || (state == ST_DIV)) && !flush);
  assign done      = (state == ST_DONE) && !flush;
  assign result    = result_q;
  assign state_dbg = state;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and a
// stalling multiply/divide path.
module execute_stage_md
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int FWD_SEL_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      data1,
  input  logic [XLEN-1:0]      data2,
  input  logic [XLEN-1:0]      immediate_data,
  input  logic [XLEN-1:0]      pc_in,
  input  control_type          control_in,
  input  logic [XLEN-1:0]      wb_forward_data,
  input  logic [XLEN-1:0]      mem_forward_data,
  input  logic [FWD_SEL_W-1:0] forward_a,
  input  logic [FWD_SEL_W-1:0] forward_b,
  output control_type          control_out,
  output logic [XLEN-1:0]      alu_data,
  output logic [XLEN-1:0]      memory_data,
  output logic                 pc_src,
  output logic [XLEN-1:0]      exe_branch_jump_address,
  output logic                 stall_req,
  output logic [1:0]           md_state
);

  localparam logic [FWD_SEL_W-1:0] FWD_MEM = FWD_SEL_W'(2);
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = FWD_SEL_W'(1);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_result, md_result, jalr_sum;
  logic            cond, md_busy, md_done;

  always_comb begin
    fwd_a = data1;
    if (forward_a == FWD_MEM)     fwd_a = mem_forward_data;
    else if (forward_a == FWD_WB) fwd_a = wb_forward_data;
    fwd_b = data2;
    if (forward_b == FWD_MEM)     fwd_b = mem_forward_data;
    else if (forward_b == FWD_WB) fwd_b = wb_forward_data;
  end

  assign alu_b = control_in.alu_src ? immediate_data : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .op (control_in.alu_op),
    .a  (fwd_a),
    .b  (alu_b),
    .y  (alu_result)
  );

  always_comb begin
    cond = 1'b0;
    case (control_in.br_funct3)
      BR_EQ:   cond = (fwd_a == fwd_b);
      BR_NE:   cond = (fwd_a != fwd_b);
      BR_LT:   cond = ($signed(fwd_a) < $signed(fwd_b));
      BR_GE:   cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  cond = (fwd_a < fwd_b);
      BR_GEU:  cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (in_valid && control_in.is_md),
    .op        (control_in.md_op),
    .a         (fwd_a),
    .b         (fwd_b),
    .busy      (md_busy),
    .done      (md_done),
    .result    (md_result),
    .state_dbg (md_state)
  );

  assign stall_req = md_busy;
  // Redirects are suppressed while the stage is holding the pipeline.
  assign pc_src    = in_valid && !stall_req &&
                     ((control_in.is_branch && cond) || control_in.is_jump || control_in.is_jalr);
  assign jalr_sum  = fwd_a + immediate_data;
  assign exe_branch_jump_address = control_in.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                                      : pc_in + immediate_data;
  assign alu_data    = md_done ? md_result : alu_result;
  assign memory_data = fwd_b;
  assign control_out = control_in;

endmodule

// File: tb/tb_execute_stage_md.sv
// Bench for execute_stage_md: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model of the stage.
module tb_execute_stage_md;
  import execute_stage_md_pkg::*;

  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 2;
  localparam int FWD_SEL_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush, in_valid;
  logic [XLEN-1:0]      data1, data2, immediate_data, pc_in, wb_forward_data, mem_forward_data;
  logic [FWD_SEL_W-1:0] forward_a, forward_b;
  control_type          control_in, control_out;
  logic [XLEN-1:0]      alu_data, memory_data, exe_branch_jump_address;
  logic                 pc_src, stall_req;
  logic [1:0]           md_state;

  always #5 clk = ~clk;

  execute_stage_md #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY), .FWD_SEL_W(FWD_SEL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .data1(data1), .data2(data2), .immediate_data(immediate_data), .pc_in(pc_in),
    .control_in(control_in), .wb_forward_data(wb_forward_data),
    .mem_forward_data(mem_forward_data), .forward_a(forward_a), .forward_b(forward_b),
    .control_out(control_out), .alu_data(alu_data), .memory_data(memory_data),
    .pc_src(pc_src), .exe_branch_jump_address(exe_branch_jump_address),
    .stall_req(stall_req), .md_state(md_state)
  );

  int tests = 0;
  int fails = 0;

  logic            chk_en = 1'b0;
  logic            exp_stall, exp_pc_src, chk_alu, chk_tgt, chk_state;
  logic [XLEN-1:0] exp_alu, exp_tgt, exp_mem;
  control_type     exp_ctrl;
  md_state_t       exp_state;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [XLEN-1:0] fwd_val(logic [1:0] sel, logic [XLEN-1:0] r);
    if (sel == 2'b10) return mem_forward_data;
    if (sel == 2'b01) return wb_forward_data;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $signed(a) >>> b[4:0];
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU:  return (a < b) ? 1 : 0;
      ALU_PASSB: return b;
      default:   return 0;
    endcase
  endfunction

  function automatic logic ref_cond(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (f3)
      BR_EQ:  return a == b;
      BR_NE:  return a != b;
      BR_LT:  return $signed(a) < $signed(b);
      BR_GE:  return $signed(a) >= $signed(b);
      BR_LTU: return a < b;
      BR_GEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_md(md_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV:    begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      MD_DIVU:   return (b == 0) ? '1 : a / b;
      MD_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32'(sa % sb);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic set_comb_expect();
    logic [XLEN-1:0] a, b, bo;
    a  = fwd_val(forward_a, data1);
    b  = fwd_val(forward_b, data2);
    bo = control_in.alu_src ? immediate_data : b;
    exp_mem    = b;
    exp_ctrl   = control_in;
    exp_alu    = ref_alu(control_in.alu_op, a, bo);
    exp_pc_src = in_valid && ((control_in.is_branch && ref_cond(control_in.br_funct3, a, b)) ||
                              control_in.is_jump || control_in.is_jalr);
    exp_tgt    = control_in.is_jalr ? ((a + immediate_data) & ~32'h1) : pc_in + immediate_data;
    chk_tgt    = exp_pc_src;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_req", 64'(stall_req), 64'(exp_stall));
      check("pc_src", 64'(pc_src), 64'(exp_pc_src));
      check("memory_data", 64'(memory_data), 64'(exp_mem));
      check("control_out", 64'(control_out), 64'(exp_ctrl));
      if (chk_alu)   check("alu_data", 64'(alu_data), 64'(exp_alu));
      if (chk_tgt)   check("target", 64'(exe_branch_jump_address), 64'(exp_tgt));
      if (chk_state) check("md_state", 64'(md_state), 64'(exp_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(control_type c, logic v, logic [XLEN-1:0] d1, logic [XLEN-1:0] d2,
                            logic [XLEN-1:0] imm, logic [XLEN-1:0] pc, logic [1:0] fa,
                            logic [1:0] fb, logic [XLEN-1:0] wbd, logic [XLEN-1:0] memd);
    control_in = c; in_valid = v; data1 = d1; data2 = d2; immediate_data = imm; pc_in = pc;
    forward_a = fa; forward_b = fb; wb_forward_data = wbd; mem_forward_data = memd;
  endtask

  task automatic prep_comb();
    set_comb_expect();
    exp_stall = 1'b0; exp_state = ST_IDLE; chk_state = 1'b1; chk_alu = 1'b1;
  endtask

  task automatic md_run(md_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b, int flush_at,
                        logic [XLEN-1:0] want);
    control_type c;
    logic [1:0]  fa, fb;
    int          lat;
    bit          is_mul, aborted;
    c = '0; c.is_md = 1'b1; c.md_op = op; c.alu_op = alu_op_t'($urandom_range(0, 10));
    fa = 2'($urandom_range(0, 3));
    fb = 2'($urandom_range(0, 3));
    if (fa == fb && (fa == 2'b01 || fa == 2'b10)) fb = 2'b00;
    set_inputs(c, 1'b1, $urandom, $urandom, $urandom, $urandom, fa, fb, $urandom, $urandom);
    case (fa) 2'b10: mem_forward_data = a; 2'b01: wb_forward_data = a; default: data1 = a; endcase
    case (fb) 2'b10: mem_forward_data = b; 2'b01: wb_forward_data = b; default: data2 = b; endcase
    is_mul = (op == MD_MUL || op == MD_MULH || op == MD_MULHSU || op == MD_MULHU);
    lat = is_mul ? MUL_LATENCY : XLEN;
    exp_q.push_back(want);
    aborted = 0;
    for (int cyc = 0; cyc <= lat + 1 && !aborted; cyc++) begin
      flush = (cyc == flush_at);
      set_comb_expect();
      exp_pc_src = 1'b0; chk_tgt = 1'b0; chk_alu = 1'b0; chk_state = 1'b1;
      exp_state = (cyc == 0) ? ST_IDLE : (cyc <= lat) ? (is_mul ? ST_MUL : ST_DIV) : ST_DONE;
      exp_stall = (cyc <= lat);
      if (cyc == lat + 1) begin
        exp_alu = exp_q.pop_front();
        chk_alu = !flush;
      end else if (flush && cyc > 0) begin
        exp_stall = 1'b0;
        void'(exp_q.pop_front());
        aborted = 1;
      end
      step();
    end
    flush = 1'b0;
    if (aborted) begin
      in_valid = 1'b0;
      prep_comb();
      step();
    end
  endtask

  function automatic logic [XLEN-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    control_type c;
    logic [2:0]  f3s [6];
    f3s = '{BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
    flush = 1'b0;
    set_inputs('0, 1'b0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    #1 reset = 1'b1;
    prep_comb();
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;

    // ADD with rs1 forwarded from MEM
    c = '0; c.alu_op = ALU_ADD;
    set_inputs(c, 1'b1, 32'h77, 32'd3, 0, 0, 2'b10, 2'b00, 32'h99, 32'd5);
    prep_comb();
    exp_alu = 32'd8; exp_mem = 32'd3;
    step();

    md_run(MD_DIV,    32'd7,         32'hFFFF_FFFE, -1, 32'hFFFF_FFFD);
    md_run(MD_REM,    32'd7,         32'hFFFF_FFFE, -1, 32'h0000_0001);
    md_run(MD_DIVU,   32'h1234,      32'd0,         -1, 32'hFFFF_FFFF);
    md_run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0000_0000);
    md_run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000);
    md_run(MD_DIV,    32'hFFFF_FFF9, 32'd0,         -1, 32'hFFFF_FFFF);
    md_run(MD_REM,    32'hFFFF_FFF9, 32'd0,         -1, 32'hFFFF_FFF9);
    md_run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'hFFFF_FFFE);
    md_run(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'h0000_0001);
    md_run(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'h0000_0000);
    md_run(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'hFFFF_FFFF);

    // BLT / BLTU / JALR
    c = '0; c.is_branch = 1'b1; c.br_funct3 = BR_LT;
    set_inputs(c, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 2'b00, 2'b00, 0, 0);
    prep_comb(); exp_pc_src = 1'b1; exp_tgt = 32'h120; chk_tgt = 1'b1;
    step();
    c.br_funct3 = BR_LTU; control_in = c;
    prep_comb(); exp_pc_src = 1'b0;
    step();
    c = '0; c.is_jalr = 1'b1;
    set_inputs(c, 1'b1, 32'h203, 0, 0, 32'h400, 2'b00, 2'b00, 0, 0);
    prep_comb(); exp_pc_src = 1'b1; exp_tgt = 32'h202; chk_tgt = 1'b1;
    step();

    // DIV flushed at cycle 10
    md_run(MD_DIV, 32'd100, 32'd7, 10, 32'd14);

    // Reset in the middle of a multiply, then a normal multiply
    c = '0; c.is_md = 1'b1; c.md_op = MD_MUL;
    set_inputs(c, 1'b1, 32'd6, 32'd7, 0, 0, 2'b00, 2'b00, 0, 0);
    set_comb_expect();
    exp_stall = 1'b1; exp_pc_src = 1'b0; exp_state = ST_IDLE; chk_alu = 1'b0; chk_state = 1'b1;
    step();
    reset = 1'b1; in_valid = 1'b0;
    prep_comb();
    step();
    reset = 1'b0;
    md_run(MD_MUL, 32'd6, 32'd7, -1, 32'd42);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        md_op_t op;
        logic [XLEN-1:0] a, b;
        int lat, fa_at;
        op = md_op_t'($urandom_range(0, 7));
        a = rnd_operand();
        b = rnd_operand();
        lat = op[2] ? XLEN : MUL_LATENCY;
        fa_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat + 1) : -1;
        md_run(op, a, b, fa_at, ref_md(op, a, b));
      end else begin
        c = '0;
        c.alu_op  = alu_op_t'($urandom_range(0, 10));
        c.alu_src = 1'($urandom_range(0, 1));
        if (kind >= 6) begin
          case ($urandom_range(0, 3))
            0: c.is_jump = 1'b1;
            1: c.is_jalr = 1'b1;
            default: c.is_branch = 1'b1;
          endcase
          c.br_funct3 = f3s[$urandom_range(0, 5)];
        end
        set_inputs(c, ($urandom_range(0, 5) != 0), rnd_operand(), rnd_operand(), $urandom,
                   $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   rnd_operand(), rnd_operand());
        flush = ($urandom_range(0, 7) == 0);
        prep_comb();
        step();
        flush = 1'b0;
      end
    end

    chk_en = 1'b0;
    if (exp_q.size() != 0) check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised successor execute stage for the RV32/RV64 in-order pipeline: forwarding muxes, single-cycle ALU, full branch-condition resolution, and an RV "M" multiply/divide path.
- Non-M instructions complete combinationally in the issue cycle, as in the current execute stage.
- M instructions run in a multi-cycle sub-unit and hold the pipeline with a stall request until their result is ready.
- Sits between the ID/EX and EX/MEM pipeline registers; hazard unit consumes `stall_req`.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- MUL_LATENCY, 2, extra cycles a multiply occupies after issue (>=1).
- FWD_SEL_W, 2, width of forward_a/forward_b selects.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  squash in-flight M operation (branch/exception from later stage).
- in_valid  in  1  ID/EX holds a live instruction.
- data1  in  XLEN  rs1 value from register file.
- data2  in  XLEN  rs2 value from register file.
- immediate_data  in  XLEN  sign-extended immediate.
- pc_in  in  XLEN  instruction PC.
- control_in  in  control_type  decoded control: alu_op, alu_src, is_branch, is_jump, is_jalr, br_funct3, is_md, md_op.
- wb_forward_data  in  XLEN  WB-stage forward value.
- mem_forward_data  in  XLEN  MEM-stage forward value.
- forward_a  in  FWD_SEL_W  rs1 forward select.
- forward_b  in  FWD_SEL_W  rs2 forward select.
- control_out  out  control_type  control_in passed through.
- alu_data  out  XLEN  ALU or M result.
- memory_data  out  XLEN  forwarded rs2 (store data).
- pc_src  out  1  redirect taken.
- exe_branch_jump_address  out  XLEN  redirect target.
- stall_req  out  1  hold IF/ID/EX; EX/MEM receives bubble.

Behaviour:
- Forwarding:
  - select 2'b10 = mem_forward_data; 2'b01 = wb_forward_data; else register value.
  - rs2 forwarding is applied before the alu_src immediate mux.
  - memory_data = forwarded rs2 (fixes the unforwarded store-data path).
- Branch:
  - br_funct3 selects EQ/NE/LT/GE/LTU/GEU on the forwarded operands.
  - pc_src = in_valid & ((is_branch & cond) | is_jump | is_jalr).
  - Target for B/JAL: pc_in + immediate_data.
  - Target for JALR: (fwd_rs1 + immediate_data) with bit0 forced to 0.
  - pc_src = 0 while stall_req = 1.
- Non-M path: alu_data combinational; stall_req = 0.
- M FSM states and transitions:
  - IDLE -> MUL or DIV when in_valid & is_md. That cycle (cycle 0) stall_req = 1 combinationally; forwarded operands and md_op are latched.
  - MUL: counter runs MUL_LATENCY cycles, then -> DONE.
  - DIV: restoring divide on magnitudes, 1 quotient bit per cycle for XLEN cycles, then -> DONE.
  - DONE: one cycle. stall_req = 0, alu_data = latched result, EX/MEM captures; -> IDLE.
  - stall_req = 1 in IDLE-issue, MUL and DIV states.
- M latency: total stall = L+1 cycles, where L = MUL_LATENCY (MUL*) or XLEN (DIV*/REM*). Result appears in cycle L+1.
- md_op encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - MULH* return the upper XLEN bits of the 2*XLEN product.
  - Signed divide: quotient sign = sign1 ^ sign2; remainder sign = dividend sign.
- Divide corner cases (same latency as normal divide):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- Abort and back-to-back:
  - flush in any non-IDLE state -> IDLE next edge, stall_req drops the same cycle, result discarded.
  - flush in IDLE has no effect.
  - Back-to-back M ops: the second issues in the cycle after DONE.
- Reset: FSM = IDLE, counter = 0, latched operands and result = 0, so stall_req = 0. Reset mid-operation aborts identically.
- Combinational outputs follow inputs during reset.

Decomposition:
- common package additions:
  - md_op_t enum (3 bits).
  - br_funct3 constants.
  - control_type fields is_md, md_op, is_jalr, br_funct3.
  - md_state_t enum {IDLE, MUL, DIV, DONE}.
- One sub-module, `muldiv_unit`, owns the FSM, counter, multiplier pipeline and divider, with a start/busy/done handshake. It is parametrised by XLEN and MUL_LATENCY.
- The existing `alu` instance is reused unchanged.

Test Plan:
- ADD with forward_a=10, mem_forward_data=5, data2=3 -> alu_data=8, stall_req=0, same cycle.
- DIV, rs1=7, rs2=0xFFFFFFFE (-2) -> stall_req high 33 cycles; cycle 33 alu_data=0xFFFFFFFD; REM -> 0x00000001.
- DIVU x/0 -> 0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF -> 0. DIV of the same operands -> 0x80000000.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> stall 3 cycles (MUL_LATENCY=2), result 0xFFFFFFFE. MUL of the same operands -> 0x00000001.
- BLT rs1=0xFFFFFFFF, rs2=1, pc_in=0x100, imm=0x20 -> pc_src=1, target 0x120. BLTU with the same operands -> pc_src=0. JALR rs1=0x203, imm=0 -> target 0x202.
- DIV issued, flush at cycle 10 -> stall_req=0 at cycle 10, FSM IDLE. Reset asserted mid-MUL -> stall_req=0 immediately, next MUL behaves normally.
